// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave: FSM state encoding, default
// frame width and the fill pattern sent when no TX data is waiting.
package spi_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } spi_state_e;

  localparam int unsigned SPI_DATA_W    = 8;
  localparam logic [7:0]  SPI_IDLE_FILL = 8'h00;

endpackage : spi_pkg

// File: rtl/spi_slave_fifo.sv
// RX frame FIFO for the SPI slave (used when SPI_SLAVE_RXFIFO_EN is defined).
// Head entry is kept in an output register so rd_data is flop-driven.
module spi_slave_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              overrun_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr, rd_ptr_next;
  logic [CNT_W-1:0]  count, count_next;
  logic [DATA_W-1:0] head_next;
  logic              full_c, pop_ok_c, wr_en_c;

  // A pop frees a slot in the same cycle, so push-on-full with pop is accepted
  always_comb begin
    full_c      = (count == CNT_W'(DEPTH));
    pop_ok_c    = pop && (count != '0);
    wr_en_c     = push && (!full_c || pop_ok_c);
    overrun_c   = push && full_c && !pop_ok_c;
    rd_ptr_next = pop_ok_c ? rd_ptr + PTR_W'(1) : rd_ptr;
    count_next  = count + CNT_W'(wr_en_c) - CNT_W'(pop_ok_c);
  end

  // Next head: bypass the write data when it lands in the slot being exposed
  always_comb begin
    head_next = rd_data;
    if (count_next != '0) begin
      if (wr_en_c && (wr_ptr == rd_ptr_next)) begin
        head_next = push_data;
      end else begin
        head_next = mem[rd_ptr_next];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (wr_en_c) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      rd_ptr   <= rd_ptr_next;
      count    <= count_next;
      rd_data  <= head_next;
      rd_valid <= (count_next != '0);
    end
  end

endmodule : spi_slave_fifo

// File: rtl/spi_slave.sv
// SPI mode-0 slave with TX holding register and RX buffering in the hclk domain.
// Define SPI_SLAVE_RXFIFO_EN to buffer RX in an RX_DEPTH-entry FIFO instead of one register.
module spi_slave
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W   = SPI_DATA_W,
  parameter int unsigned RX_DEPTH = 4
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              spi_clk,
  input  logic              spi_nss,
  input  logic              spi_mosi,
  output logic              spi_miso,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  input  logic              rx_ready_i,
  output logic              rx_overrun_o,
  input  logic              rx_overrun_clr_i,
  output logic              busy_o
);

  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  if ((RX_DEPTH < 2) || ((RX_DEPTH & (RX_DEPTH - 1)) != 0)) begin : g_bad_rx_depth
    $error("spi_slave: RX_DEPTH must be a power of two >= 2");
  end

  logic [1:0]        clk_sync, nss_sync, mosi_sync;
  logic              clk_q, nss_q;
  logic              clk_s, nss_s, mosi_s;
  logic              clk_rise_c, clk_fall_c, nss_fall_c;

  spi_state_e        state, state_next;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] rx_sr, tx_sr, tx_sr_next, tx_hold, rx_word_c;
  logic              last_bit_c, load_c, sample_c, shift_c, abort_c;
  logic              push_c, pop_c, ovr_set_c;

  // Synchronizers reset to bus-idle levels so no spurious edge follows reset
  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      clk_sync  <= 2'b00;
      nss_sync  <= 2'b11;
      mosi_sync <= 2'b00;
      clk_q     <= 1'b0;
      nss_q     <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], spi_clk};
      nss_sync  <= {nss_sync[0], spi_nss};
      mosi_sync <= {mosi_sync[0], spi_mosi};
      clk_q     <= clk_sync[1];
      nss_q     <= nss_sync[1];
    end
  end

  always_comb begin
    clk_s      = clk_sync[1];
    nss_s      = nss_sync[1];
    mosi_s     = mosi_sync[1];
    clk_rise_c = clk_s && !clk_q;
    clk_fall_c = !clk_s && clk_q;
    nss_fall_c = !nss_s && nss_q;
    last_bit_c = (bit_cnt == CNT_W'(DATA_W - 1));
    rx_word_c  = DATA_W'({rx_sr, mosi_s});
    pop_c      = rx_valid_o && rx_ready_i;
  end

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // No shift on the falling edge right after a frame boundary: the freshly
  // loaded MSB must stay on MISO for the next frame's first bit
  always_comb begin
    state_next = state;
    load_c     = 1'b0;
    sample_c   = 1'b0;
    shift_c    = 1'b0;
    abort_c    = 1'b0;
    push_c     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (nss_fall_c) begin
          state_next = ST_SHIFT;
          load_c     = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (nss_s) begin
          state_next = ST_IDLE;
          abort_c    = 1'b1;
        end else begin
          sample_c = clk_rise_c;
          shift_c  = clk_fall_c && (bit_cnt != '0);
          push_c   = clk_rise_c && last_bit_c;
          load_c   = clk_rise_c && last_bit_c;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    tx_sr_next = tx_sr;
    if (load_c) begin
      tx_sr_next = tx_ready_o ? DATA_W'(SPI_IDLE_FILL) : tx_hold;
    end else if (shift_c) begin
      tx_sr_next = tx_sr << 1;
    end
  end

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      bit_cnt    <= '0;
      rx_sr      <= '0;
      tx_sr      <= '0;
      tx_hold    <= '0;
      tx_ready_o <= 1'b1;
      spi_miso   <= 1'b0;
      busy_o     <= 1'b0;
    end else begin
      if (abort_c) begin
        bit_cnt <= '0;
      end else if (sample_c) begin
        bit_cnt <= last_bit_c ? '0 : bit_cnt + CNT_W'(1);
      end
      if (sample_c) begin
        rx_sr <= rx_word_c;
      end
      tx_sr    <= tx_sr_next;
      spi_miso <= (state_next == ST_SHIFT) ? tx_sr_next[DATA_W-1] : 1'b0;
      busy_o   <= (state_next == ST_SHIFT);
      // Holding register: drained by a frame load, refilled by the host
      if (load_c && !tx_ready_o) begin
        tx_ready_o <= 1'b1;
      end else if (tx_valid_i && tx_ready_o) begin
        tx_hold    <= tx_data_i;
        tx_ready_o <= 1'b0;
      end
    end
  end

`ifdef SPI_SLAVE_RXFIFO_EN
  spi_slave_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (RX_DEPTH)
  ) u_rx_fifo (
    .clk       (hclk),
    .rst_n     (hresetn),
    .push      (push_c),
    .push_data (rx_word_c),
    .pop       (pop_c),
    .rd_data   (rx_data_o),
    .rd_valid  (rx_valid_o),
    .overrun_c (ovr_set_c)
  );
`else
  // Single RX register; a pop in the same cycle makes room for the push
  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      rx_data_o  <= '0;
      rx_valid_o <= 1'b0;
    end else if (push_c && (!rx_valid_o || pop_c)) begin
      rx_data_o  <= rx_word_c;
      rx_valid_o <= 1'b1;
    end else if (pop_c) begin
      rx_valid_o <= 1'b0;
    end
  end

  assign ovr_set_c = push_c && rx_valid_o && !pop_c;
`endif

  // Sticky overrun flag; a new overrun beats a coincident clear
  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      rx_overrun_o <= 1'b0;
    end else if (ovr_set_c) begin
      rx_overrun_o <= 1'b1;
    end else if (rx_overrun_clr_i) begin
      rx_overrun_o <= 1'b0;
    end
  end

endmodule : spi_slave

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: bit-banged SPI master with a queue of
// expected RX frames popped on every rx_valid_o/rx_ready_i handshake.
module tb_spi_slave;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned RX_DEPTH = 4;
`ifdef SPI_SLAVE_RXFIFO_EN
  localparam int unsigned RX_CAP = RX_DEPTH;
`else
  localparam int unsigned RX_CAP = 1;
`endif

  logic              hclk             = 1'b0;
  logic              hresetn          = 1'b0;
  logic              spi_clk          = 1'b0;
  logic              spi_nss          = 1'b1;
  logic              spi_mosi         = 1'b0;
  logic              spi_miso;
  logic [DATA_W-1:0] tx_data_i        = '0;
  logic              tx_valid_i       = 1'b0;
  logic              tx_ready_o;
  logic [DATA_W-1:0] rx_data_o;
  logic              rx_valid_o;
  logic              rx_ready_i       = 1'b0;
  logic              rx_overrun_o;
  logic              rx_overrun_clr_i = 1'b0;
  logic              busy_o;

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] rx_q[$];

  always #5 hclk = ~hclk;

  spi_slave #(
    .DATA_W   (DATA_W),
    .RX_DEPTH (RX_DEPTH)
  ) dut (
    .hclk             (hclk),
    .hresetn          (hresetn),
    .spi_clk          (spi_clk),
    .spi_nss          (spi_nss),
    .spi_mosi         (spi_mosi),
    .spi_miso         (spi_miso),
    .tx_data_i        (tx_data_i),
    .tx_valid_i       (tx_valid_i),
    .tx_ready_o       (tx_ready_o),
    .rx_data_o        (rx_data_o),
    .rx_valid_o       (rx_valid_o),
    .rx_ready_i       (rx_ready_i),
    .rx_overrun_o     (rx_overrun_o),
    .rx_overrun_clr_i (rx_overrun_clr_i),
    .busy_o           (busy_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge hclk);
    #1;
  endtask

  // Scoreboard: every accepted RX word must match the oldest expectation
  always @(negedge hclk) begin
    if (rx_valid_o && rx_ready_i) begin
      if (rx_q.size() == 0) begin
        check_eq("rx_unexpected", 32'(rx_data_o), 32'hFFFF_FFFF);
      end else begin
        check_eq("rx_data", 32'(rx_data_o), 32'(rx_q.pop_front()));
      end
    end
  end

  task automatic write_tx(input logic [7:0] d);
    int n = 0;
    while (!tx_ready_o && n < 50) begin
      tick(1);
      n++;
    end
    check_eq("tx_ready_wait", 32'(tx_ready_o), 32'd1);
    tx_data_i  = d;
    tx_valid_i = 1'b1;
    tick(1);
    tx_valid_i = 1'b0;
  endtask

  // Mode 0, 8-hclk period; MISO is checked just before each rising edge
  task automatic send_bits(input logic [7:0] mosi, input int nbits, input logic [7:0] miso_exp,
                           input bit chk_miso, input bit clr_last);
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = mosi[7-i];
      tick(4);
      if (chk_miso) check_eq("miso_bit", 32'(spi_miso), 32'(miso_exp[7-i]));
      spi_clk = 1'b1;
      if (clr_last && (i == nbits - 1)) begin
        tick(2);
        rx_overrun_clr_i = 1'b1;
        tick(1);
        rx_overrun_clr_i = 1'b0;
        tick(1);
      end else begin
        tick(4);
      end
      spi_clk = 1'b0;
    end
  endtask

  task automatic nss_release();
    tick(4);
    spi_nss = 1'b1;
    tick(8);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (rx_q.size() != 0 && n < 300) begin
      tick(1);
      n++;
    end
    check_eq("rx_drain", 32'(rx_q.size()), 32'd0);
    tick(2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tick(3);
    check_eq("rst_miso", 32'(spi_miso), 32'd0);
    check_eq("rst_tx_ready", 32'(tx_ready_o), 32'd1);
    check_eq("rst_rx_valid", 32'(rx_valid_o), 32'd0);
    check_eq("rst_rx_data", 32'(rx_data_o), 32'd0);
    check_eq("rst_overrun", 32'(rx_overrun_o), 32'd0);
    check_eq("rst_busy", 32'(busy_o), 32'd0);
    hresetn = 1'b1;
    tick(4);

    // TX 0xA5 while master sends 0x3C
    rx_ready_i = 1'b1;
    write_tx(8'hA5);
    check_eq("tx_ready_full", 32'(tx_ready_o), 32'd0);
    rx_q.push_back(8'h3C);
    spi_nss = 1'b0;
    send_bits(8'h3C, 8, 8'hA5, 1'b1, 1'b0);
    check_eq("busy_in_frame", 32'(busy_o), 32'd1);
    check_eq("tx_ready_loaded", 32'(tx_ready_o), 32'd1);
    nss_release();
    check_eq("busy_idle", 32'(busy_o), 32'd0);
    check_eq("miso_idle", 32'(spi_miso), 32'd0);
    wait_drain();

    // No TX data: MISO all zero
    rx_q.push_back(8'h27);
    spi_nss = 1'b0;
    send_bits(8'h27, 8, 8'h00, 1'b1, 1'b0);
    nss_release();
    wait_drain();

    // Three back-to-back frames with consumer stalled
    rx_ready_i = 1'b0;
    rx_q.push_back(8'h27);
    if (RX_CAP >= 3) begin
      rx_q.push_back(8'h6B);
      rx_q.push_back(8'hA3);
    end
    spi_nss = 1'b0;
    send_bits(8'h27, 8, 8'h00, 1'b1, 1'b0);
    send_bits(8'h6B, 8, 8'h00, 1'b1, 1'b0);
    send_bits(8'hA3, 8, 8'h00, 1'b1, 1'b0);
    nss_release();
    check_eq("stall_valid", 32'(rx_valid_o), 32'd1);
    check_eq("stall_data", 32'(rx_data_o), 32'h27);
    check_eq("stall_overrun", 32'(rx_overrun_o), (RX_CAP < 3) ? 32'd1 : 32'd0);
    tick(5);
    check_eq("stall_data_stable", 32'(rx_data_o), 32'h27);
    rx_ready_i = 1'b1;
    wait_drain();
    rx_overrun_clr_i = 1'b1;
    tick(1);
    rx_overrun_clr_i = 1'b0;
    tick(1);
    check_eq("overrun_cleared", 32'(rx_overrun_o), 32'd0);

    // nss released after 5 bits, then a full 0x81 frame
    spi_nss = 1'b0;
    send_bits(8'hFF, 5, 8'h00, 1'b0, 1'b0);
    nss_release();
    check_eq("partial_no_push", 32'(rx_valid_o), 32'd0);
    rx_q.push_back(8'h81);
    spi_nss = 1'b0;
    send_bits(8'h81, 8, 8'h00, 1'b1, 1'b0);
    nss_release();
    wait_drain();
    check_eq("partial_no_overrun", 32'(rx_overrun_o), 32'd0);

    // Fill the buffer, then overrun in the same cycle as a clear pulse
    rx_ready_i = 1'b0;
    spi_nss = 1'b0;
    for (int k = 0; k < int'(RX_CAP); k++) begin
      rx_q.push_back(8'(8'h10 + k));
      send_bits(8'(8'h10 + k), 8, 8'h00, 1'b0, 1'b0);
    end
    check_eq("fill_no_overrun", 32'(rx_overrun_o), 32'd0);
    send_bits(8'hEE, 8, 8'h00, 1'b0, 1'b1);
    nss_release();
    check_eq("ovr_set_wins", 32'(rx_overrun_o), 32'd1);
    rx_overrun_clr_i = 1'b1;
    tick(1);
    rx_overrun_clr_i = 1'b0;
    tick(1);
    check_eq("ovr_clr_alone", 32'(rx_overrun_o), 32'd0);
    rx_ready_i = 1'b1;
    wait_drain();

    // Reset pulse mid-frame
    write_tx(8'h5A);
    spi_nss = 1'b0;
    send_bits(8'hC3, 3, 8'h5A, 1'b1, 1'b0);
    hresetn = 1'b0;
    tick(1);
    hresetn = 1'b1;
    check_eq("mid_rst_miso", 32'(spi_miso), 32'd0);
    check_eq("mid_rst_tx_ready", 32'(tx_ready_o), 32'd1);
    check_eq("mid_rst_rx_valid", 32'(rx_valid_o), 32'd0);
    check_eq("mid_rst_rx_data", 32'(rx_data_o), 32'd0);
    check_eq("mid_rst_overrun", 32'(rx_overrun_o), 32'd0);
    check_eq("mid_rst_busy", 32'(busy_o), 32'd0);
    tick(4);
    send_bits(8'h00, 5, 8'h00, 1'b1, 1'b0);
    nss_release();
    tick(6);
    check_eq("mid_rst_no_push", 32'(rx_valid_o), 32'd0);
    check_eq("rx_q_empty", 32'(rx_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_spi_slave

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have parameter DATA_W, default 8, frame width in bits, MSB first.
REQ-002 SHALL have parameter RX_DEPTH, default 4, RX FIFO depth (power of two); used only when SPI_SLAVE_RXFIFO_EN is defined.
REQ-003 SHALL have port hclk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port hresetn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port spi_clk  input  1  serial clock from the SPI master, asynchronous to hclk.
REQ-006 SHALL have port spi_nss  input  1  slave select, active-low, asynchronous.
REQ-007 SHALL have port spi_mosi  input  1  serial data from the master.
REQ-008 SHALL have port spi_miso  output  1  serial data to the master.
REQ-009 SHALL have ports tx_data_i  input  DATA_W, tx_valid_i  input  1, tx_ready_o  output  1: one-entry TX holding register, valid/ready handshake.
REQ-010 SHALL have ports rx_data_o  output  DATA_W, rx_valid_o  output  1, rx_ready_i  input  1: received frames, valid/ready handshake.
REQ-011 SHALL have ports rx_overrun_o  output  1 (sticky) and rx_overrun_clr_i  input  1 (clear pulse).
REQ-012 SHALL have port busy_o  output  1  high while in SHIFT.

Function
REQ-013 SHALL pass spi_clk, spi_nss, spi_mosi through 2-flop synchronizers; edges detected on synchronized spi_clk; supported spi_clk period >= 8 hclk cycles.
REQ-014 SHALL implement SPI mode 0: sample MOSI on spi_clk rising edge, update MISO on falling edge.
REQ-015 SHALL use FSM IDLE/SHIFT: IDLE->SHIFT on synchronized nss falling; SHIFT->IDLE on synchronized nss rising.
REQ-016 SHALL, on IDLE->SHIFT and after each completed frame with nss still low, load TX shift register from holding register if full (holding becomes empty, tx_ready_o=1 next cycle), else load 0x00.
REQ-017 SHALL drive spi_miso = TX shift MSB in SHIFT, 0 in IDLE.
REQ-018 SHALL count sampled bits 0..DATA_W-1; on DATA_W-th rising edge push the RX shift value into the RX buffer and wrap the count to 0.
REQ-019 SHALL accept TX write when tx_valid_i && tx_ready_o; tx_ready_o = holding register empty.
REQ-020 SHALL pop RX when rx_valid_o && rx_ready_i; rx_data_o stable while rx_valid_o && !rx_ready_i.
REQ-021 SHALL, on frame completion with RX buffer full, discard the new frame, keep stored data, set rx_overrun_o next cycle.
REQ-022 SHALL clear rx_overrun_o on rx_overrun_clr_i; simultaneous set and clear -> set wins.
REQ-023 SHALL, on simultaneous pop and push when full, accept both with no overrun.
REQ-024 SHALL, on nss rising mid-frame, discard partial bits, reset the bit count, and not push RX.
REQ-025 SHALL make received byte visible on rx_valid_o within 4 hclk cycles of the synchronized final rising edge.

Reset
REQ-026 SHALL on hresetn low at hclk edge: FSM IDLE, counters 0, buffers empty, spi_miso=0, tx_ready_o=1, rx_valid_o=0, rx_data_o=0, rx_overrun_o=0, busy_o=0, synchronizers to idle levels (nss=1, clk=0).
REQ-027 SHALL abort any frame in progress on reset without pushing RX.

Configuration
REQ-028 SHALL, with SPI_SLAVE_RXFIFO_EN defined, buffer RX in a RX_DEPTH-entry FIFO; overrun only when RX_DEPTH entries held.
REQ-029 SHALL, without SPI_SLAVE_RXFIFO_EN, buffer RX in a single holding register; overrun when it is full.

Structure
REQ-030 SHALL place FSM state enum, DATA_W default and 0x00 idle-fill constant in shared package spi_pkg.
REQ-031 SHALL instantiate sub-module spi_slave_fifo for RX buffering when SPI_SLAVE_RXFIFO_EN is defined.

Verification
REQ-032 SHALL cover: write tx 0xA5, master sends 0x3C (period 8 hclk) -> MISO bits 10100101, rx_data_o=0x3C, rx_valid_o=1.
REQ-033 SHALL cover: no tx data, master sends 0x27 -> MISO all 0, rx_data_o=0x27.
REQ-034 SHALL cover: nss low for 3 frames 0x27,0x6B,0xA3, rx_ready_i=0 -> FIFO build holds all three; single-register build holds 0x27, rx_overrun_o=1.
REQ-035 SHALL cover: nss released after 5 bits, then full frame 0x81 -> only 0x81 received, no overrun.
REQ-036 SHALL cover: rx_overrun_clr_i pulsed same cycle as new overrun -> rx_overrun_o stays 1; next clear alone -> 0.
REQ-037 SHALL cover: hresetn low mid-frame for 1 cycle -> all outputs at reset values, tx_ready_o=1, no RX push.
